enemy_formation: RTL and testbench

//  Parametrised ROWSxCOLS enemy formation for Space Invaders: owns formation position, march/descend

---
 rtl/invaders_pkg.sv | 21 ++
 rtl/formation_step_timer.sv | 33 +++
 rtl/enemy_formation.sv | 246 ++++++++++++++++++++++++
 tb/tb_enemy_formation.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared types and constants for the invaders formation logic.
package invaders_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH   = 3'd1,
    ST_DESCEND = 3'd2,
    ST_WON     = 3'd3,
    ST_LOST    = 3'd4
  } formation_state_t;

  // 24-bit RGB per row, index 0 is the top row.
  localparam logic [7:0][23:0] ROW_COLOUR = {
    24'hFF0000, 24'hFFFFFF, 24'h0080FF, 24'hFF8000,
    24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'hFF00FF
  };

endpackage

// File: rtl/formation_step_timer.sv
// Variable-period tick generator; a new period is latched whenever the count restarts.
module formation_step_timer #(
  parameter int PER_W        = 20,
  parameter int RESET_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PER_W-1:0] i_period,
  input  logic             i_en,
  input  logic             i_clear,
  output logic             o_tick
);

  logic [PER_W-1:0] r_count;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] w_load_period;

  assign w_load_period = (i_period == '0) ? PER_W'(1) : i_period;
  assign o_tick        = i_en && !i_clear && (r_count == r_period - PER_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_period <= PER_W'(RESET_PERIOD);
    end else if (i_clear || o_tick) begin
      r_count  <= '0;
      r_period <= w_load_period;
    end else if (i_en) begin
      r_count  <= r_count + PER_W'(1);
    end
  end

endmodule

// File: rtl/enemy_formation.sv
// ROWSxCOLS invader formation: motion, alive state, bullet hits and pixel colour.
// Optional FORMATION_SPEEDUP_EN shortens the step period as enemies die.
module enemy_formation
  import invaders_pkg::*;
#(
  parameter int ROWS     = 3,
  parameter int COLS     = 8,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 24,
  parameter int PITCH_X  = 64,
  parameter int PITCH_Y  = 50,
  parameter int X0       = 40,
  parameter int Y0       = 40,
  parameter int STEP_X   = 8,
  parameter int STEP_Y   = 16,
  parameter int X_MAX    = 639,
  parameter int Y_LIMIT  = 440,
  parameter int TICK_DIV = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          h_counter,
  input  logic [9:0]          v_counter,
  input  logic                hit_valid,
  input  logic [9:0]          hit_x,
  input  logic [9:0]          hit_y,
  output logic                hit_ack,
  output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] hit_index,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic [$clog2(ROWS*COLS+1)-1:0] alive_count,
  output logic [9:0]          base_x,
  output logic [9:0]          base_y,
  output logic                all_dead,
  output logic                invaded,
  output logic [7:0]          R,
  output logic [7:0]          G,
  output logic [7:0]          B
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PER_W = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;

  formation_state_t r_state;
  logic [9:0]       r_base_x;
  logic [9:0]       r_base_y;
  logic             r_dir_right;
  logic [N-1:0]     r_alive;
  logic [CNT_W-1:0] r_alive_count;
  logic             r_hit_ack;
  logic [IDX_W-1:0] r_hit_index;
  logic             r_all_dead;
  logic             r_invaded;
  logic [23:0]      r_rgb;

  logic [COLS-1:0]  w_col_alive;
  logic [ROWS-1:0]  w_row_alive;
  logic [3:0]       w_rmax;
  logic [3:0]       w_lmin;
  logic [2:0]       w_bottom;
  logic [10:0]      w_right_px;
  logic [10:0]      w_left_px;
  logic [10:0]      w_bottom_px;
  logic             w_edge;
  logic             w_invade;
  logic             w_active;
  logic             w_tick;
  logic [PER_W-1:0] w_period;
  logic [4:0]       w_hc;
  logic [3:0]       w_hr;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_hit;
  logic             w_last_kill;
  logic [4:0]       w_pc;
  logic [3:0]       w_pr;
  logic [IDX_W-1:0] w_pix_idx;
  logic             w_pix_on;

  // {found, column} of the sprite column covering px, if any.
  function automatic logic [4:0] locate_col(input logic [9:0] px, input logic [9:0] bx);
    logic [10:0] lo;
    logic [4:0]  res;
    res = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      lo = 11'(bx) + 11'(c * PITCH_X);
      if ({1'b0, px} >= lo && {1'b0, px} <= lo + 11'(SPR_W - 1)) res = {1'b1, 4'(c)};
    end
    return res;
  endfunction

  function automatic logic [3:0] locate_row(input logic [9:0] py, input logic [9:0] by);
    logic [10:0] lo;
    logic [3:0]  res;
    res = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      lo = 11'(by) + 11'(r * PITCH_Y);
      if ({1'b0, py} >= lo && {1'b0, py} <= lo + 11'(SPR_H - 1)) res = {1'b1, 3'(r)};
    end
    return res;
  endfunction

  always_comb begin
    w_col_alive = '0;
    w_row_alive = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (r_alive[r*COLS + c]) begin
          w_col_alive[c] = 1'b1;
          w_row_alive[r] = 1'b1;
        end
      end
    end
    w_rmax   = '0;
    w_lmin   = '0;
    w_bottom = '0;
    for (int unsigned c = 0; c < COLS; c++)
      if (w_col_alive[c]) w_rmax = 4'(c);
    for (int unsigned k = 0; k < COLS; k++)
      if (w_col_alive[COLS-1-k]) w_lmin = 4'(COLS - 1 - k);
    for (int unsigned r = 0; r < ROWS; r++)
      if (w_row_alive[r]) w_bottom = 3'(r);
  end

  assign w_right_px  = 11'(r_base_x) + 11'(w_rmax * PITCH_X) + 11'(SPR_W - 1 + STEP_X);
  assign w_left_px   = 11'(r_base_x) + 11'(w_lmin * PITCH_X);
  assign w_bottom_px = 11'(r_base_y) + 11'(w_bottom * PITCH_Y) + 11'(SPR_H);

  // Leftward also stops when base_x itself would underflow, even if column 0 is empty.
  assign w_edge   = r_dir_right ? (w_right_px >= 11'(X_MAX))
                                : (w_left_px < 11'(STEP_X) || r_base_x < 10'(STEP_X));
  assign w_invade = (|r_alive) && (w_bottom_px >= 11'(Y_LIMIT));
  assign w_active = (r_state == ST_MARCH) || (r_state == ST_DESCEND);

  assign w_hc        = locate_col(hit_x, r_base_x);
  assign w_hr        = locate_row(hit_y, r_base_y);
  assign w_hit_idx   = IDX_W'(w_hr[2:0] * COLS + w_hc[3:0]);
  assign w_hit       = hit_valid && w_active && w_hc[4] && w_hr[3] && r_alive[w_hit_idx];
  assign w_last_kill = w_hit && (r_alive_count == CNT_W'(1));

`ifdef FORMATION_SPEEDUP_EN
  always_comb begin
    w_period = PER_W'(TICK_DIV);
    if (r_alive_count == CNT_W'(1))       w_period = PER_W'(TICK_DIV >> 3);
    else if (32'(r_alive_count) <= N / 4) w_period = PER_W'(TICK_DIV >> 2);
    else if (32'(r_alive_count) <= N / 2) w_period = PER_W'(TICK_DIV >> 1);
    if (w_period == '0) w_period = PER_W'(1);
  end
`else
  assign w_period = PER_W'(TICK_DIV);
`endif

  formation_step_timer #(
    .PER_W       (PER_W),
    .RESET_PERIOD(TICK_DIV)
  ) u_step_timer (
    .clk     (clk),
    .rst     (reset),
    .i_period(w_period),
    .i_en    (w_active),
    .i_clear (start),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_base_x      <= 10'(X0);
      r_base_y      <= 10'(Y0);
      r_dir_right   <= 1'b1;
      r_alive       <= '1;
      r_alive_count <= CNT_W'(N);
      r_hit_ack     <= 1'b0;
      r_hit_index   <= '0;
      r_all_dead    <= 1'b0;
      r_invaded     <= 1'b0;
    end else if (start) begin
      r_state       <= ST_MARCH;
      r_base_x      <= 10'(X0);
      r_base_y      <= 10'(Y0);
      r_dir_right   <= 1'b1;
      r_alive       <= '1;
      r_alive_count <= CNT_W'(N);
      r_hit_ack     <= 1'b0;
      r_hit_index   <= '0;
      r_all_dead    <= 1'b0;
      r_invaded     <= 1'b0;
    end else begin
      r_hit_ack <= 1'b0;
      if (w_active) begin
        if (w_hit) begin
          r_alive[w_hit_idx] <= 1'b0;
          r_alive_count      <= r_alive_count - CNT_W'(1);
          r_hit_index        <= w_hit_idx;
          r_hit_ack          <= 1'b1;
        end
        if (w_last_kill || r_alive_count == '0) begin
          r_all_dead <= 1'b1;
          r_state    <= ST_WON;
        end else if (w_invade) begin
          r_invaded <= 1'b1;
          r_state   <= ST_LOST;
        end else if (w_tick) begin
          if (r_state == ST_MARCH) begin
            if (w_edge) begin
              r_base_y    <= r_base_y + 10'(STEP_Y);
              r_dir_right <= ~r_dir_right;
              r_state     <= ST_DESCEND;
            end else if (r_dir_right) begin
              r_base_x <= r_base_x + 10'(STEP_X);
            end else begin
              r_base_x <= r_base_x - 10'(STEP_X);
            end
          end else begin
            r_state <= ST_MARCH;
          end
        end
      end
    end
  end

  assign w_pc      = locate_col(h_counter, r_base_x);
  assign w_pr      = locate_row(v_counter, r_base_y);
  assign w_pix_idx = IDX_W'(w_pr[2:0] * COLS + w_pc[3:0]);
  assign w_pix_on  = (r_state != ST_IDLE) && w_pc[4] && w_pr[3] && r_alive[w_pix_idx] &&
                     (h_counter < 10'(H_RES)) && (v_counter < 10'(V_RES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rgb <= '0;
    else       r_rgb <= w_pix_on ? ROW_COLOUR[w_pr[2:0]] : '0;
  end

  assign hit_ack     = r_hit_ack;
  assign hit_index   = r_hit_index;
  assign alive_mask  = r_alive;
  assign alive_count = r_alive_count;
  assign base_x      = r_base_x;
  assign base_y      = r_base_y;
  assign all_dead    = r_all_dead;
  assign invaded     = r_invaded;
  assign R           = r_rgb[23:16];
  assign G           = r_rgb[15:8];
  assign B           = r_rgb[7:0];

endmodule

// File: tb/tb_enemy_formation.sv
// Self-checking bench for enemy_formation with TICK_DIV=4.
module tb_enemy_formation;

  logic        clk = 1'b0;
  logic        reset, start, hit_valid;
  logic [9:0]  h_counter, v_counter, hit_x, hit_y;
  logic        hit_ack, all_dead, invaded;
  logic [4:0]  hit_index, alive_count;
  logic [23:0] alive_mask;
  logic [9:0]  base_x, base_y;
  logic [7:0]  R, G, B;

  int n_tests = 0;
  int n_fail  = 0;
  int sb_q[$];

  typedef struct {
    int hx;
    int hy;
    bit exp_hit;
    int exp_idx;
  } hit_vec_t;
  hit_vec_t vecs[10];

  enemy_formation #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .h_counter(h_counter), .v_counter(v_counter),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ack(hit_ack), .hit_index(hit_index),
    .alive_mask(alive_mask), .alive_count(alive_count),
    .base_x(base_x), .base_y(base_y),
    .all_dead(all_dead), .invaded(invaded),
    .R(R), .G(G), .B(B)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard consumer: every ack must match the oldest expected kill.
  always @(negedge clk) begin
    if (reset === 1'b0 && hit_ack === 1'b1) begin
      int e;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: hit_index=%0d, expected no ack", hit_index);
      end else begin
        e = sb_q.pop_front();
        check("ack_index", 32'(hit_index), 32'(e));
      end
    end
  end

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_move(input int limit, input bit y_only, output bit ok, output int cycles);
    logic [9:0] x0, y0;
    x0 = base_x;
    y0 = base_y;
    ok = 1'b0;
    cycles = 0;
    while (cycles < limit && !ok) begin
      @(negedge clk);
      cycles++;
      if (base_y !== y0 || (!y_only && base_x !== x0)) ok = 1'b1;
    end
  endtask

  task automatic kill(input int idx);
    int r, c;
    r = idx / 8;
    c = idx % 8;
    hit_x = 10'(int'(base_x) + c * 64 + 16);
    hit_y = 10'(int'(base_y) + r * 50 + 12);
    hit_valid = 1'b1;
    sb_q.push_back(idx);
    @(negedge clk) hit_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cyc;
    logic [9:0] fx, fy;

    vecs[0] = '{173, 93, 1'b1, 10};
    vecs[1] = '{80, 45, 1'b0, 0};
    vecs[2] = '{40, 40, 1'b1, 0};
    vecs[3] = '{71, 63, 1'b1, 0};
    vecs[4] = '{72, 40, 1'b0, 0};
    vecs[5] = '{40, 64, 1'b0, 0};
    vecs[6] = '{519, 163, 1'b1, 23};
    vecs[7] = '{520, 163, 1'b0, 0};
    vecs[8] = '{104, 90, 1'b1, 9};
    vecs[9] = '{39, 39, 1'b0, 0};

    reset = 1'b1; start = 1'b0; hit_valid = 1'b0;
    hit_x = '0; hit_y = '0; h_counter = 10'd50; v_counter = 10'd50;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_mask", 32'(alive_mask), 32'h00FFFFFF);
    check("rst_count", 32'(alive_count), 32'd24);
    check("rst_base", {12'b0, base_x, base_y}, {12'b0, 10'd40, 10'd40});
    check("rst_flags", {29'b0, all_dead, invaded, hit_ack}, 32'd0);
    repeat (10) @(negedge clk);
    check("idle_base_x", 32'(base_x), 32'd40);
    check("idle_rgb", {8'b0, R, G, B}, 32'd0);

    // Pixel colour and first step
    do_start();
    @(negedge clk);
    check("pix_row0", {8'b0, R, G, B}, 32'h00FF00FF);
    v_counter = 10'd92;
    @(negedge clk);
    check("pix_row1", {8'b0, R, G, B}, 32'h0000FFFF);
    v_counter = 10'd70;
    @(negedge clk);
    check("pix_gap", {8'b0, R, G, B}, 32'd0);
    check("march_pre_x", 32'(base_x), 32'd40);
    @(negedge clk);
    check("march_first_x", 32'(base_x), 32'd48);

    wait_move(200, 1'b1, ok, cyc);
    if (!ok) timeout("descend_wait");
    check("descend_x", 32'(base_x), 32'd152);
    check("descend_y", 32'(base_y), 32'd56);
    wait_move(40, 1'b0, ok, cyc);
    if (!ok) timeout("left_wait");
    check("left_step_x", 32'(base_x), 32'd144);

    // Asynchronous reset mid-march
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("amid_mask", 32'(alive_mask), 32'h00FFFFFF);
    check("amid_base", {12'b0, base_x, base_y}, {12'b0, 10'd40, 10'd40});
    check("amid_out", {5'b0, all_dead, invaded, hit_ack, R, G, B}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (12) @(negedge clk);
    check("amid_idle", {12'b0, base_x, base_y}, {12'b0, 10'd40, 10'd40});

    // Hit table, fresh formation per vector
    for (int i = 0; i < 10; i++) begin
      do_start();
      hit_x = 10'(vecs[i].hx);
      hit_y = 10'(vecs[i].hy);
      hit_valid = 1'b1;
      if (vecs[i].exp_hit) sb_q.push_back(vecs[i].exp_idx);
      @(negedge clk) hit_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_count", i), 32'(alive_count), vecs[i].exp_hit ? 32'd23 : 32'd24);
      if (vecs[i].exp_hit)
        check($sformatf("vec%0d_bit", i), 32'(alive_mask[vecs[i].exp_idx]), 32'd0);
      check($sformatf("vec%0d_ack_low", i), 32'(hit_ack), 32'd0);
    end

    // Second hit on an already-dead enemy gives no ack
    do_start();
    hit_x = 10'd173; hit_y = 10'd93; hit_valid = 1'b1;
    sb_q.push_back(10);
    @(negedge clk);
    check("dead_first_ack", 32'(hit_ack), 32'd1);
    @(negedge clk) hit_valid = 1'b0;
    check("dead_second_ack", 32'(hit_ack), 32'd0);
    check("dead_count", 32'(alive_count), 32'd23);

    // Column 7 removed: right edge moves out
    do_start();
    hit_x = 10'd504; hit_y = 10'd52; hit_valid = 1'b1; sb_q.push_back(7);
    @(negedge clk) hit_y = 10'd102; sb_q.push_back(15);
    @(negedge clk) hit_y = 10'd152; sb_q.push_back(23);
    @(negedge clk) hit_valid = 1'b0;
    @(negedge clk);
    check("col7_count", 32'(alive_count), 32'd21);
    wait_move(400, 1'b1, ok, cyc);
    if (!ok) timeout("col7_descend_wait");
    check("col7_descend_x", 32'(base_x), 32'd216);

    // Kill everything
    do_start();
    for (int i = 0; i < 24; i++) kill(i);
    check("won_all_dead", 32'(all_dead), 32'd1);
    check("won_count", 32'(alive_count), 32'd0);
    check("won_mask", 32'(alive_mask), 32'd0);
    fx = base_x; fy = base_y;
    repeat (20) @(negedge clk);
    check("won_frozen", {12'b0, base_x, base_y}, {12'b0, fx, fy});
    do_start();
    check("restart_mask", 32'(alive_mask), 32'h00FFFFFF);
    check("restart_all_dead", 32'(all_dead), 32'd0);
    repeat (4) @(negedge clk);
    check("restart_march_x", 32'(base_x), 32'd48);

    // Invasion with no kills
    wait_move(1, 1'b0, ok, cyc);
    cyc = 0;
    while (invaded !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (invaded !== 1'b1) timeout("invade_wait");
    check("invade_y", 32'(base_y), 32'd328);
    check("invade_all_dead", 32'(all_dead), 32'd0);
    repeat (10) @(negedge clk);
    check("lost_frozen_y", 32'(base_y), 32'd328);
    check("lost_sticky", 32'(invaded), 32'd1);

    // Step period with 12 enemies left
    do_start();
    for (int i = 0; i < 12; i++) kill(i);
    check("half_count", 32'(alive_count), 32'd12);
    wait_move(20, 1'b0, ok, cyc);
    if (!ok) timeout("period_sync_wait");
    wait_move(20, 1'b0, ok, cyc);
    if (!ok) timeout("period_wait");
`ifdef FORMATION_SPEEDUP_EN
    check("period_half", 32'(cyc), 32'd2);
`else
    check("period_fixed", 32'(cyc), 32'd4);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
